// File: rtl/branch_unit.sv
// Branch/jump resolution for the RV32I execute stage: combinational taken/redirect
// decision plus free-running branch/jump statistics counters.
module branch_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       brOp,
  input  logic [XLEN-1:0]  ruRs1,
  input  logic [XLEN-1:0]  ruRs2,
  output logic             nextPcSrc,
  output logic             brIllegal,
  output logic [CNT_W-1:0] brCount,
  output logic [CNT_W-1:0] takenCount,
  output logic [CNT_W-1:0] jumpCount
);

  // funct3 compare; reserved encodings 010/011 never take
  function automatic logic branchCond(input logic [2:0] f3,
                                      input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sa = a;
    sb = b;
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return sa < sb;
      3'b101:  return sa >= sb;
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  logic isJump;
  logic isCond;
  logic isReserved;
  logic condValid;
  logic condTaken;

  always_comb begin
    isJump     = brOp[4];
    isCond     = (brOp[4:3] == 2'b01);
    isReserved = isCond && (brOp[2:1] == 2'b01);
    condValid  = isCond && !isReserved;
    condTaken  = condValid && branchCond(brOp[2:0], ruRs1, ruRs2);
    nextPcSrc  = !rst && (isJump || condTaken);
    brIllegal  = !rst && isReserved;
  end

  // statistics counters, wrap modulo 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      brCount    <= '0;
      takenCount <= '0;
      jumpCount  <= '0;
    end else begin
      if (condValid) brCount    <= brCount + CNT_W'(1);
      if (condTaken) takenCount <= takenCount + CNT_W'(1);
      if (isJump)    jumpCount  <= jumpCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Bench for branch_unit: directed vector table, reset/wrap sequences and
// randomized traffic checked against a plain-arithmetic reference model.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  brOp;
  logic [31:0] ruRs1, ruRs2;
  logic        nextPcSrc, brIllegal;
  logic [31:0] brCount, takenCount, jumpCount;
  logic        sNextPcSrc, sBrIllegal;
  logic [2:0]  sBrCount, sTakenCount, sJumpCount;

  int nTests = 0;
  int nFail  = 0;

  logic [31:0] mBr, mTk, mJmp;

  always #5 clk = ~clk;

  branch_unit dut (
    .clk(clk), .rst(rst), .brOp(brOp), .ruRs1(ruRs1), .ruRs2(ruRs2),
    .nextPcSrc(nextPcSrc), .brIllegal(brIllegal),
    .brCount(brCount), .takenCount(takenCount), .jumpCount(jumpCount)
  );

  // narrow-counter instance so wrap-around is reachable in a few cycles
  branch_unit #(.XLEN(32), .CNT_W(3)) dutSmall (
    .clk(clk), .rst(rst), .brOp(brOp), .ruRs1(ruRs1), .ruRs2(ruRs2),
    .nextPcSrc(sNextPcSrc), .brIllegal(sBrIllegal),
    .brCount(sBrCount), .takenCount(sTakenCount), .jumpCount(sJumpCount)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        expPc;
    logic        expIll;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint toSigned(input logic [31:0] v);
    longint r;
    r = longint'(v);
    if (v >= 32'h8000_0000) r = r - 64'sd4294967296;
    return r;
  endfunction

  // returns {isCondBranch, taken, illegal} straight from the ISA rules
  function automatic logic [2:0] refModel(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint ua, ub, sa, sb;
    ua = longint'(a);
    ub = longint'(b);
    sa = toSigned(a);
    sb = toSigned(b);
    if (op[4]) return 3'b010;
    if (!op[3]) return 3'b000;
    case (op[2:0])
      3'd0: return {1'b1, (ua == ub), 1'b0};
      3'd1: return {1'b1, (ua != ub), 1'b0};
      3'd4: return {1'b1, (sa <  sb), 1'b0};
      3'd5: return {1'b1, (sa >= sb), 1'b0};
      3'd6: return {1'b1, (ua <  ub), 1'b0};
      3'd7: return {1'b1, (ua >= ub), 1'b0};
      default: return 3'b001;
    endcase
  endfunction

  // apply one cycle of stimulus; entered and left just after a rising edge
  task automatic step(input logic r, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic expPc, input logic expIll);
    logic [2:0] m;
    rst = r; brOp = op; ruRs1 = a; ruRs2 = b;
    #2;
    chk("nextPcSrc", {31'b0, nextPcSrc}, {31'b0, expPc});
    chk("brIllegal", {31'b0, brIllegal}, {31'b0, expIll});
    m = refModel(op, a, b);
    @(posedge clk);
    if (r) begin
      mBr = 0; mTk = 0; mJmp = 0;
    end else begin
      if (m[2]) mBr++;
      if (m[2] && m[1]) mTk++;
      if (op[4]) mJmp++;
    end
    #1;
    chk("brCount", brCount, mBr);
    chk("takenCount", takenCount, mTk);
    chk("jumpCount", jumpCount, mJmp);
    chk("smallBrCount", {29'b0, sBrCount}, {29'b0, mBr[2:0]});
    chk("smallTakenCount", {29'b0, sTakenCount}, {29'b0, mTk[2:0]});
    chk("smallJumpCount", {29'b0, sJumpCount}, {29'b0, mJmp[2:0]});
  endtask

  initial begin
    vec_t vecs[10];
    logic [2:0] m;
    logic [4:0] op;
    logic [31:0] a, b;
    logic r;

    vecs[0] = '{5'b01000, 32'd7, 32'd3, 1'b0, 1'b0};
    vecs[1] = '{5'b01101, 32'd7, 32'd3, 1'b1, 1'b0};
    vecs[2] = '{5'b01100, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0};
    vecs[3] = '{5'b01110, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0};
    vecs[4] = '{5'b00101, 32'd9, 32'd9, 1'b0, 1'b0};
    vecs[5] = '{5'b10000, 32'd0, 32'd1, 1'b1, 1'b0};
    vecs[6] = '{5'b01010, 32'd5, 32'd5, 1'b0, 1'b1};
    vecs[7] = '{5'b01011, 32'd5, 32'd6, 1'b0, 1'b1};
    vecs[8] = '{5'b01111, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0};
    vecs[9] = '{5'b01101, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0};

    mBr = 0; mTk = 0; mJmp = 0;
    rst = 1'b1; brOp = 5'b10000; ruRs1 = 0; ruRs2 = 0;
    @(posedge clk); #1;

    // reset held two cycles with a jump and a reserved code present
    step(1'b1, 5'b10000, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 5'b01010, 32'd5, 32'd5, 1'b0, 1'b0);
    chk("rstBrCount", brCount, 32'd0);
    chk("rstJumpCount", jumpCount, 32'd0);

    foreach (vecs[i])
      step(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expPc, vecs[i].expIll);
    chk("tableBrCount", brCount, 32'd6);
    chk("tableTakenCount", takenCount, 32'd3);
    chk("tableJumpCount", jumpCount, 32'd1);

    // mid-run reset with a jump present clears everything
    step(1'b1, 5'b10001, 32'd1, 32'd2, 1'b0, 1'b0);
    chk("midRstJump", jumpCount, 32'd0);

    // narrow takenCount reaches all-ones then wraps to zero
    for (int k = 0; k < 7; k++) step(1'b0, 5'b01000, 32'd5, 32'd5, 1'b1, 1'b0);
    chk("smallTakenAllOnes", {29'b0, sTakenCount}, 32'd7);
    step(1'b0, 5'b01000, 32'd5, 32'd5, 1'b1, 1'b0);
    chk("smallTakenWrap", {29'b0, sTakenCount}, 32'd0);
    chk("wideTakenNoWrap", takenCount, 32'd8);

    for (int k = 0; k < 400; k++) begin
      op = 5'($urandom_range(0, 31));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ 32'h8000_0000;
        default: b = $urandom;
      endcase
      r = ($urandom_range(0, 49) == 0);
      m = refModel(op, a, b);
      step(r, op, a, b, !r && m[1], !r && m[0]);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
